// File: rtl/parking_lot_controller.sv
// ---------------------------------------------------------------------------
// parking_lot_controller
//
// Central occupancy controller for a two-lane parking lot. Folds the per-lane
// enter/exit pulses into a saturating occupancy count and runs the entry-gate
// FSM that grants entry while space remains.
//
// Parameters
//   CAPACITY      number of spaces (1..255)
//   GATE_TIMEOUT  max cycles the gate stays open waiting for an entry (1..255)
//
// Ports
//   clk            clock, rising edge
//   Reset          synchronous, active-high reset
//   en0 / en1      lane 0/1 car-entered pulse, one entry per asserted cycle
//   ex0 / ex1      lane 0/1 car-exited pulse, one exit per asserted cycle
//   req_in         car waiting at the entry gate (level)
//   gate_open      gate actuator command (registered Moore output)
//   count          current occupancy (registered)
//   full / empty   count == CAPACITY / count == 0
//   overflow_err   sticky: an entry was counted while already full
//   underflow_err  sticky: an exit was counted while already empty
// ---------------------------------------------------------------------------
module parking_lot_controller #(
    parameter int CAPACITY     = 25,
    parameter int GATE_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            Reset,
    input  logic                            en0,
    input  logic                            ex0,
    input  logic                            en1,
    input  logic                            ex1,
    input  logic                            req_in,
    output logic                            gate_open,
    output logic [$clog2(CAPACITY+1)-1:0]   count,
    output logic                            full,
    output logic                            empty,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    localparam int CW = $clog2(CAPACITY+1);
    // Two extra bits: one for headroom above CAPACITY, one for sign.
    localparam int SW = CW + 2;
    localparam logic signed [SW-1:0] CAP_S  = SW'(CAPACITY);
    localparam logic        [7:0]    TMR_LD = 8'(GATE_TIMEOUT - 1);

    // -----------------------------------------------------------------------
    // Occupancy counter
    // -----------------------------------------------------------------------
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [SW-1:0]        ent_w, ext_w;
    logic signed [SW-1:0] sum_s;

    always_comb begin
        ent_w = SW'(en0) + SW'(en1);
        ext_w = SW'(ex0) + SW'(ex1);
        // Entries and exits in the same cycle net out before clamping, so a
        // full lot with one in and one out stays full without an error.
        sum_s = $signed({2'b00, count_q}) + $signed(ent_w) - $signed(ext_w);

        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (sum_s > CAP_S) begin
            count_d = CW'(CAPACITY);
            ovf_d   = 1'b1;
        end else if (sum_s < $signed(SW'(0))) begin
            count_d = '0;
            unf_d   = 1'b1;
        end else begin
            count_d = sum_s[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count         = count_q;
    assign full          = (count_q == CW'(CAPACITY));
    assign empty         = (count_q == '0);
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    // -----------------------------------------------------------------------
    // Entry-gate FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN     = 2'd1,
        COOLDOWN = 2'd2
    } gate_state_e;

    gate_state_e state_q;
    logic [7:0]  timer_q;
    logic        gate_open_q;

    // Grants look at the registered full flag, so an exit in the same cycle
    // only enables a grant on the following edge.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gate_open_q <= 1'b0;
                    if (req_in && !full) begin
                        state_q     <= OPEN;
                        timer_q     <= TMR_LD;
                        gate_open_q <= 1'b1;
                    end
                end
                OPEN: begin
                    // Close on an entry from either lane, when the other
                    // lane filled the lot, or when the wait budget runs out.
                    if (en0 || en1 || full || (timer_q == '0)) begin
                        state_q     <= COOLDOWN;
                        gate_open_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                COOLDOWN: begin
                    // The cooldown cycle is the single enforced closed cycle.
                    // Its exit takes the idle grant decision directly, so a
                    // held request reopens after exactly one closed cycle.
                    gate_open_q <= 1'b0;
                    state_q     <= IDLE;
                    if (req_in && !full) begin
                        state_q     <= OPEN;
                        timer_q     <= TMR_LD;
                        gate_open_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    timer_q     <= '0;
                    gate_open_q <= 1'b0;
                end
            endcase
        end
    end

    assign gate_open = gate_open_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
module tb_parking_lot_controller;

    localparam int CAP = 3;
    localparam int GTO = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic       en0, ex0, en1, ex1, req_in;
    logic       gate_open, full, empty, overflow_err, underflow_err;
    logic [1:0] count;

    int total = 0;
    int bad   = 0;

    parking_lot_controller #(.CAPACITY(CAP), .GATE_TIMEOUT(GTO)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .en0          (en0),
        .ex0          (ex0),
        .en1          (en1),
        .ex1          (ex1),
        .req_in       (req_in),
        .gate_open    (gate_open),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a0, input logic a1, input logic b0, input logic b1);
        en0 = a0; en1 = a1; ex0 = b0; ex1 = b1;
        step();
        en0 = 0; en1 = 0; ex0 = 0; ex1 = 0;
    endtask

    logic [9:0] gexp;

    initial begin
        Reset = 1; en0 = 0; ex0 = 0; en1 = 0; ex1 = 0; req_in = 0;
        step(); step();
        Reset = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_gate",  32'(gate_open), 0);
        chk("rst_ovf",   32'(overflow_err), 0);
        chk("rst_unf",   32'(underflow_err), 0);

        // three entries fill the lot
        for (int i = 1; i <= 3; i++) begin
            pulse(1, 0, 0, 0);
            chk($sformatf("fill_count%0d", i), 32'(count), 32'(i));
        end
        chk("fill_full",  32'(full), 1);
        chk("fill_empty", 32'(empty), 0);
        chk("fill_ovf",   32'(overflow_err), 0);
        chk("fill_unf",   32'(underflow_err), 0);

        // entry while full saturates and sets sticky overflow
        pulse(0, 1, 0, 0);
        chk("ovf_count", 32'(count), 3);
        chk("ovf_flag",  32'(overflow_err), 1);
        step();
        chk("ovf_sticky", 32'(overflow_err), 1);
        req_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("full_nogrant%0d", i), 32'(gate_open), 0);
        end
        req_in = 0;

        // drain to zero, then double exit underflows
        pulse(0, 0, 1, 1);
        chk("drain_count1", 32'(count), 1);
        pulse(0, 0, 1, 0);
        chk("drain_count0", 32'(count), 0);
        chk("drain_unf0",   32'(underflow_err), 0);
        pulse(0, 0, 1, 1);
        chk("unf_count", 32'(count), 0);
        chk("unf_flag",  32'(underflow_err), 1);
        chk("unf_empty", 32'(empty), 1);
        pulse(1, 1, 0, 0);
        chk("dual_en_count", 32'(count), 2);
        pulse(0, 0, 1, 0);
        chk("to_one_count", 32'(count), 1);

        // held request, no entry: 4 open, 1 closed, 4 open, 1 closed
        gexp = 10'b0111101111;  // bit i = expected gate after edge i+1
        req_in = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("timeout_gate%0d", i), 32'(gate_open), 32'(gexp[i]));
        end
        req_in = 0;
        step(); step();
        chk("timeout_idle", 32'(gate_open), 0);

        // count=2, entry on 2nd open cycle closes gate and fills lot
        pulse(1, 0, 0, 0);
        chk("pre_count2", 32'(count), 2);
        req_in = 1;
        step();
        chk("grant_open1", 32'(gate_open), 1);
        step();
        chk("grant_open2", 32'(gate_open), 1);
        pulse(1, 0, 0, 0);
        chk("entry_close", 32'(gate_open), 0);
        chk("entry_count", 32'(count), 3);
        chk("entry_full",  32'(full), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("full_regrant%0d", i), 32'(gate_open), 0);
        end

        // count=2, gate open, other lane fills the lot
        req_in = 0;
        pulse(0, 0, 0, 1);
        chk("other_count2", 32'(count), 2);
        chk("other_notfull", 32'(full), 0);
        req_in = 1;
        step();
        chk("other_open", 32'(gate_open), 1);
        pulse(0, 1, 0, 0);
        chk("other_close", 32'(gate_open), 0);
        chk("other_count3", 32'(count), 3);

        // reopen then reset while open
        req_in = 0;
        pulse(1, 0, 1, 0);      // net zero at full: unchanged
        chk("net_count", 32'(count), 3);
        pulse(0, 0, 1, 0);
        chk("reopen_count", 32'(count), 2);
        req_in = 1;
        step();
        chk("reopen_gate", 32'(gate_open), 1);
        Reset = 1;
        step();
        Reset = 0; req_in = 0;
        chk("midrst_gate",  32'(gate_open), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_ovf",   32'(overflow_err), 0);
        chk("midrst_unf",   32'(underflow_err), 0);
        chk("midrst_empty", 32'(empty), 1);

        // full plus one in and one out: no error; then net +1 at full clamps
        pulse(1, 1, 0, 0);
        pulse(1, 0, 0, 0);
        chk("refill_count", 32'(count), 3);
        pulse(1, 0, 0, 1);
        chk("netfull_count", 32'(count), 3);
        chk("netfull_ovf",   32'(overflow_err), 0);
        pulse(1, 1, 1, 0);
        chk("netplus_count", 32'(count), 3);
        chk("netplus_ovf",   32'(overflow_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
